// File: rtl/mem_map_pkg.sv
// Shared address map, field widths and decode helper for the data-memory responder.
package mem_map_pkg;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned LED_W   = 10;
  localparam int unsigned SW_W    = 10;
  localparam int unsigned TSTAT_W = 1;

  localparam logic [ADDR_W-1:0] RAM_LIMIT  = 9'h100;
  localparam logic [ADDR_W-1:0] ADDR_LED   = 9'h100;
  localparam logic [ADDR_W-1:0] ADDR_SW    = 9'h140;
  localparam logic [ADDR_W-1:0] ADDR_TCNT  = 9'h180;
  localparam logic [ADDR_W-1:0] ADDR_TCMP  = 9'h181;
  localparam logic [ADDR_W-1:0] ADDR_TSTAT = 9'h182;

  localparam logic [DATA_W-1:0] TCMP_RESET = 16'hFFFF;

  typedef enum logic [2:0] {
    RegRam,
    RegLed,
    RegSw,
    RegTcnt,
    RegTcmp,
    RegTstat,
    RegNone
  } region_e;

  function automatic region_e decode_region(input logic [ADDR_W-1:0] addr);
    region_e r;
    r = RegNone;
    if (addr < RAM_LIMIT) begin
      r = RegRam;
    end else begin
      case (addr)
        ADDR_LED:   r = RegLed;
        ADDR_SW:    r = RegSw;
        ADDR_TCNT:  r = RegTcnt;
        ADDR_TCMP:  r = RegTcmp;
        ADDR_TSTAT: r = RegTstat;
        default:    r = RegNone;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Prescaled free-running counter with compare register and sticky match flag.
module mmio_timer
  import mem_map_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_tcnt,
  input  logic              wr_tcmp,
  input  logic              wr_tstat,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] tcnt,
  output logic [DATA_W-1:0] tcmp,
  output logic              match
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [DATA_W-1:0] tcnt_q, tcnt_d;
  logic [DATA_W-1:0] tcmp_q, tcmp_d;
  logic              tstat_q, tstat_d;
  logic              tick;

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
    tcnt_d  = tick ? tcnt_q + 1'b1 : tcnt_q;
    // A counter clear overrides any tick landing on the same edge.
    if (wr_tcnt) begin
      presc_d = '0;
      tcnt_d  = '0;
    end
    tcmp_d  = wr_tcmp ? wdata : tcmp_q;
    tstat_d = tstat_q;
    if (wr_tstat && wdata[0]) begin
      tstat_d = 1'b0;
    end
    // Set on the transition into the compare value; set beats a same-cycle clear.
    if ((tcnt_d != tcnt_q) && (tcnt_d == tcmp_q)) begin
      tstat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tcnt_q  <= '0;
      tcmp_q  <= TCMP_RESET;
      tstat_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      tstat_q <= tstat_d;
    end
  end

  assign tcnt  = tcnt_q;
  assign tcmp  = tcmp_q;
  assign match = tstat_q;

endmodule

// File: rtl/data_mem_responder.sv
// Pipeline data-memory stage: word RAM plus LED, switch and timer MMIO with registered reads.
module data_mem_responder
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 256,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic [DATA_W-1:0] wdata_mem,
  input  logic              write_mem,
  output logic [DATA_W-1:0] rdata_mem,
  input  logic [SW_W-1:0]   switches,
  output logic [LED_W-1:0]  leds,
  output logic              timer_irq
);

  localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [DATA_W-1:0] ram [RAM_WORDS];

  region_e           region;
  logic              ram_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_ram, wr_led, wr_tcnt, wr_tcmp, wr_tstat;

  logic [LED_W-1:0]  leds_q, leds_d;
  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] tcnt, tcmp;
  logic              match;

  always_comb begin
    region   = decode_region(addr_mem);
    ram_hit  = (region == RegRam) && (32'(addr_mem) < RAM_WORDS);
    ram_idx  = addr_mem[RAM_AW-1:0];
    wr_ram   = write_mem && ram_hit;
    wr_led   = write_mem && (region == RegLed);
    wr_tcnt  = write_mem && (region == RegTcnt);
    wr_tcmp  = write_mem && (region == RegTcmp);
    wr_tstat = write_mem && (region == RegTstat);
  end

  // RAM has no reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (wr_ram && rst_n) begin
      ram[ram_idx] <= wdata_mem;
    end
  end

  always_comb begin
    leds_d = wr_led ? wdata_mem[LED_W-1:0] : leds_q;
  end

  // Read mux samples pre-edge state, which gives read-first behaviour on collisions.
  always_comb begin
    rdata_d = '0;
    case (region)
      RegRam:   rdata_d = ram_hit ? ram[ram_idx] : '0;
      RegLed:   rdata_d = {{(DATA_W - LED_W){1'b0}}, leds_q};
      RegSw:    rdata_d = {{(DATA_W - SW_W){1'b0}}, sw_sync_q};
      RegTcnt:  rdata_d = tcnt;
      RegTcmp:  rdata_d = tcmp;
      RegTstat: rdata_d = {{(DATA_W - TSTAT_W){1'b0}}, match};
      default:  rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      rdata_q   <= '0;
    end else begin
      leds_q    <= leds_d;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
      rdata_q   <= rdata_d;
    end
  end

  mmio_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_tcnt  (wr_tcnt),
    .wr_tcmp  (wr_tcmp),
    .wr_tstat (wr_tstat),
    .wdata    (wdata_mem),
    .tcnt     (tcnt),
    .tcmp     (tcmp),
    .match    (match)
  );

  assign rdata_mem = rdata_q;
  assign leds      = leds_q;
  assign timer_irq = match;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  RAM_WORDS, 256, RAM depth in 16-bit words, mapped from 0x000
  PRESCALE, 1, clk cycles per timer tick, >=1
REQ-002 Ports SHALL be (name direction width meaning):
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  addr_mem  in  9  word address from pipeline memory stage
  wdata_mem  in  16  store data
  write_mem  in  1  store strobe, 1 = write this cycle
  rdata_mem  out  16  load data returned to writeback stage
  switches  in  10  asynchronous board switch inputs
  leds  out  10  LED register contents
  timer_irq  out  1  sticky compare-match flag
REQ-003 Clocking SHALL be one clock, clk; reset SHALL be rst_n, asynchronous assert, active-low.

Function
REQ-004 Address map SHALL be: 0x000-0x0FF RAM (RAM_WORDS words); 0x100 LED (R/W, bits[9:0]); 0x140 SW (RO); 0x180 TCNT (RO, write clears); 0x181 TCMP (R/W); 0x182 TSTAT (bit0 match, write-1-to-clear); all other addresses read 0x0000, writes ignored.
REQ-005 Writes SHALL commit on the rising edge where write_mem=1, using addr_mem/wdata_mem sampled at that edge.
REQ-006 Reads SHALL have one-cycle latency: rdata_mem valid the cycle after addr_mem is presented, held as a register.
REQ-007 rdata_mem SHALL be updated every cycle regardless of write_mem, with no read-enable.
REQ-008 Same-address read and write in one cycle SHALL return old data (read-first) the next cycle.
REQ-009 LED writes SHALL store wdata_mem[9:0]; reads SHALL return {6'b0, leds}.
REQ-010 switches SHALL pass through a two-flop synchronizer; SW reads SHALL return {6'b0, synchronized value}.
REQ-011 Prescaler SHALL count 0..PRESCALE-1 and emit one tick on wrap; TCNT SHALL increment by 1 per tick, wrapping 0xFFFF->0x0000.
REQ-012 A write to TCNT SHALL clear TCNT and the prescaler; it SHALL take priority over a same-cycle tick.
REQ-013 The cycle TCNT transitions to a value equal to TCMP SHALL set TSTAT[0]; TSTAT[0] SHALL stay set until cleared.
REQ-014 Writing TSTAT with wdata_mem[0]=1 SHALL clear TSTAT[0]; same-cycle set and clear SHALL leave it set (set wins).
REQ-015 timer_irq SHALL equal TSTAT[0]; TSTAT reads SHALL return {15'b0, TSTAT[0]}.
REQ-016 TCNT reads SHALL return the value before that cycle's increment.

Reset
REQ-017 rst_n low SHALL immediately clear rdata_mem, leds, TCNT, prescaler, TCMP (to 0xFFFF), TSTAT, synchronizer flops.
REQ-018 RAM contents SHALL NOT be reset; RAM reads after reset return the last written value.
REQ-019 Reset asserted mid-operation SHALL discard a same-edge write to any register; first post-release edge behaves as normal operation.

Structure
REQ-020 Address constants (RAM limit, LED, SW, TCNT, TCMP, TSTAT) and register field widths SHALL live in shared package mem_map_pkg.
REQ-021 Prescaler, TCNT, TCMP, TSTAT SHALL be one sub-module, mmio_timer; RAM and decode stay in data_mem_responder.

Verification
REQ-022 Write 0x1234 to 0x005, then read 0x005 -> rdata_mem=0x1234 one cycle after address presented.
REQ-023 Write 0xABCD to 0x005 while reading 0x005 (old 0x1234) -> next cycle rdata_mem=0x1234; following read -> 0xABCD.
REQ-024 Write 0xFFFF to 0x100 -> leds=0x3FF, read 0x100 -> 0x03FF; read 0x1F0 -> 0x0000.
REQ-025 PRESCALE=4, TCMP=0x0003, clear TCNT -> timer_irq rises 12 cycles after the clearing edge; write 0x0001 to 0x182 -> timer_irq=0.
REQ-026 switches=0x2AA applied -> SW read returns 0x02AA no earlier than 2 edges later.
REQ-027 Assert rst_n low mid-count with leds=0x155 -> leds=0, timer_irq=0, rdata_mem=0 immediately; RAM 0x005 still reads 0xABCD after release.
